// File: rtl/led_sel_sequencer.sv
// Step/mode push-button front end that produces the 3-bit sel code for the led decoder.
// Two debounced buttons drive a MANUAL/AUTO selector with modulo-8 up/down stepping.

module led_sel_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic press_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (din_i != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d    = din_i;
                press_d = din_i;   // only the rising debounced edge is an event
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;
endmodule

// state  | meaning
// MANUAL | sel steps once per debounced step press (reset state)
// AUTO   | sel steps every STEP_CYCLES cycles; step presses ignored
module led_sel_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_step_i,
    input  logic       btn_mode_i,
    input  logic       dir_i,
    output logic [2:0] sel_o,
    output logic       sel_changed_o,
    output logic       auto_mode_o
);
    localparam int PS_W = $clog2(STEP_CYCLES);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(STEP_CYCLES - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    // bit 2 = dir, bit 1 = mode, bit 0 = step
    logic [2:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {dir_i, btn_mode_i, btn_step_i};
            sync2_q <= sync1_q;
        end
    end

    logic step_press, mode_press;

    led_sel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (sync2_q[0]),
        .press_o (step_press)
    );

    led_sel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .din_i   (sync2_q[1]),
        .press_o (mode_press)
    );

    state_t          state_q;
    logic [PS_W-1:0] presc_q;
    logic [2:0]      sel_q;
    logic            sel_changed_q;
    logic [2:0]      sel_step_d;

    assign sel_step_d = sync2_q[2] ? (sel_q - 3'd1) : (sel_q + 3'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= MANUAL;
            presc_q       <= '0;
            sel_q         <= 3'b000;
            sel_changed_q <= 1'b0;
        end else begin
            sel_changed_q <= 1'b0;
            if (state_q == MANUAL) begin
                if (step_press) begin
                    sel_q         <= sel_step_d;
                    sel_changed_q <= 1'b1;
                end
                if (mode_press) begin
                    state_q <= AUTO;
                    presc_q <= '0;
                end
            end else begin
                // a mode press on the terminal count suppresses that step
                if (mode_press) begin
                    state_q <= MANUAL;
                    presc_q <= '0;
                end else if (presc_q == PS_MAX) begin
                    presc_q       <= '0;
                    sel_q         <= sel_step_d;
                    sel_changed_q <= 1'b1;
                end else begin
                    presc_q <= presc_q + PS_W'(1);
                end
            end
        end
    end

    assign sel_o         = sel_q;
    assign sel_changed_o = sel_changed_q;
    assign auto_mode_o   = (state_q == AUTO);
endmodule

// File: tb/tb_led_sel_sequencer.sv
// Directed bench for led_sel_sequencer: reset, manual stepping, glitch rejection,
// auto cadence, mode/terminal-count collision and reset during auto mode.

module tb_led_sel_sequencer;
    logic       clk;
    logic       rst;
    logic       btn_step;
    logic       btn_mode;
    logic       dir;
    logic [2:0] sel;
    logic       sel_changed;
    logic       auto_mode;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_sel  = 3'b000;

    led_sel_sequencer #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(8)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .btn_step_i    (btn_step),
        .btn_mode_i    (btn_mode),
        .dir_i         (dir),
        .sel_o         (sel),
        .sel_changed_o (sel_changed),
        .auto_mode_o   (auto_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (sel !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sel: got %b expected 000", sel);
        end
        n_checks++;
        if (sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sel_changed: got %b expected 0", sel_changed);
        end
        n_checks++;
        if (auto_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_auto_mode: got %b expected 0", auto_mode);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (sel !== 3'b000 || sel_changed !== 1'b0 || auto_mode !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got sel=%b chg=%b auto=%b expected 000/0/0",
                         i, sel, sel_changed, auto_mode);
            end
        end
    endtask

    task automatic test_manual_up();
        dir = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 8; k++) begin
            btn_step = 1'b1;
            repeat (6) tick();
            n_checks++;
            if (sel !== exp_sel || sel_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_up_early press %0d: got sel=%b chg=%b expected %b/0",
                         k, sel, sel_changed, exp_sel);
            end
            tick();
            exp_sel = exp_sel + 3'd1;
            n_checks++;
            if (sel !== exp_sel || sel_changed !== 1'b1) begin
                n_fail++;
                $display("FAIL manual_up_step press %0d: got sel=%b chg=%b expected %b/1",
                         k, sel, sel_changed, exp_sel);
            end
            tick();
            n_checks++;
            if (sel !== exp_sel || sel_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL manual_up_pulse press %0d: got sel=%b chg=%b expected %b/0",
                         k, sel, sel_changed, exp_sel);
            end
            repeat (2) tick();
            btn_step = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                n_checks++;
                if (sel !== exp_sel || sel_changed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL manual_up_release press %0d cyc %0d: got sel=%b chg=%b expected %b/0",
                             k, i, sel, sel_changed, exp_sel);
                end
            end
        end
        n_checks++;
        if (sel !== 3'b000) begin
            n_fail++;
            $display("FAIL manual_up_wrap: got %b expected 000", sel);
        end
    endtask

    task automatic test_down_glitch();
        dir = 1'b1;
        repeat (4) tick();
        btn_step = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (sel !== 3'b000 || sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL down_early: got sel=%b chg=%b expected 000/0", sel, sel_changed);
        end
        tick();
        exp_sel = 3'b111;
        n_checks++;
        if (sel !== 3'b111 || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: got sel=%b chg=%b expected 111/1", sel, sel_changed);
        end
        repeat (3) tick();
        btn_step = 1'b0;
        repeat (10) tick();
        btn_step = 1'b1;
        repeat (3) tick();
        btn_step = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_checks++;
            if (sel !== 3'b111 || sel_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: got sel=%b chg=%b expected 111/0", i, sel, sel_changed);
            end
        end
        dir = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_auto();
        logic exp_chg;
        logic exp_auto;
        btn_mode = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (auto_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_entry_early: got auto=%b expected 0", auto_mode);
        end
        tick();
        n_checks++;
        if (auto_mode !== 1'b1 || sel !== exp_sel || sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_entry: got auto=%b sel=%b chg=%b expected 1/%b/0",
                     auto_mode, sel, sel_changed, exp_sel);
        end
        for (int c = 1; c <= 48; c++) begin
            btn_mode = (c <= 3) || (c >= 27 && c <= 36);
            btn_step = (c >= 9 && c <= 18);
            tick();
            exp_chg  = (c % 8 == 0) && (c <= 32);
            exp_auto = (c <= 32);
            if (exp_chg) exp_sel = exp_sel + 3'd1;
            n_checks++;
            if (sel !== exp_sel || sel_changed !== exp_chg || auto_mode !== exp_auto) begin
                n_fail++;
                $display("FAIL auto_run cyc %0d: got sel=%b chg=%b auto=%b expected %b/%b/%b",
                         c, sel, sel_changed, auto_mode, exp_sel, exp_chg, exp_auto);
            end
        end
    endtask

    task automatic test_collision();
        logic exp_chg;
        logic exp_auto;
        btn_mode = 1'b1;
        repeat (6) tick();
        tick();
        n_checks++;
        if (auto_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_entry: got auto=%b expected 1", auto_mode);
        end
        for (int c = 1; c <= 30; c++) begin
            btn_mode = (c <= 3) || (c >= 10 && c <= 19);
            tick();
            exp_chg  = (c == 8);
            exp_auto = (c < 16);
            if (exp_chg) exp_sel = exp_sel + 3'd1;
            n_checks++;
            if (sel !== exp_sel || sel_changed !== exp_chg || auto_mode !== exp_auto) begin
                n_fail++;
                $display("FAIL collision cyc %0d: got sel=%b chg=%b auto=%b expected %b/%b/%b",
                         c, sel, sel_changed, auto_mode, exp_sel, exp_chg, exp_auto);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic exp_chg;
        btn_mode = 1'b1;
        repeat (7) tick();
        for (int c = 1; c <= 10; c++) begin
            btn_mode = (c <= 3);
            btn_step = (c >= 7);
            tick();
            exp_chg = (c == 8);
            if (exp_chg) exp_sel = exp_sel + 3'd1;
            n_checks++;
            if (sel !== exp_sel || sel_changed !== exp_chg || auto_mode !== 1'b1) begin
                n_fail++;
                $display("FAIL midrun_auto cyc %0d: got sel=%b chg=%b auto=%b expected %b/%b/1",
                         c, sel, sel_changed, auto_mode, exp_sel, exp_chg);
            end
        end
        n_checks++;
        if (sel !== 3'b101) begin
            n_fail++;
            $display("FAIL midrun_presel: got %b expected 101", sel);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_sel = 3'b000;
        n_checks++;
        if (sel !== 3'b000 || sel_changed !== 1'b0 || auto_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got sel=%b chg=%b auto=%b expected 000/0/0",
                     sel, sel_changed, auto_mode);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (sel !== 3'b000 || sel_changed !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_hold cyc %0d: got sel=%b chg=%b expected 000/0", i, sel, sel_changed);
            end
        end
        tick();
        n_checks++;
        if (sel !== 3'b001 || sel_changed !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_held_press: got sel=%b chg=%b expected 001/1", sel, sel_changed);
        end
        tick();
        n_checks++;
        if (sel !== 3'b001 || sel_changed !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_pulse: got sel=%b chg=%b expected 001/0", sel, sel_changed);
        end
        btn_step = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        rst      = 1'b1;
        btn_step = 1'b0;
        btn_mode = 1'b0;
        dir      = 1'b0;
        test_reset();
        test_manual_up();
        test_down_glitch();
        test_auto();
        test_collision();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
